rtf65002_icachefill: RTL and testbench
======================================

# rtf65002_icachefill

Instruction-cache line-fill and invalidate controller for the rtf65002 core. It consumes the two hit flags produced by the I-cache tag memory for the current fetch address and the following 8-byte window. On a miss it fetches the missing 16-byte line(s) over the WISHBONE master bus and writes each word into the cache write port, so that tag and data RAMs are filled. It also runs a full-cache invalidate sweep on request.

## Interface

Parameters:
- LINES, 1024: number of cache lines; the index is pc[13:4].
- HOLD, 2: cycles the controller ignores hit flags after the last cache write, covering the tag-RAM read latency.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- chk_i  in  1  hit0_i, hit1_i and pc_i are valid this cycle.
- pc_i  in  32  registered fetch address aligned with the hit flags.
- hit0_i  in  1  tag hit for the line of pc_i.
- hit1_i  in  1  tag hit for the line of pc_i+8.
- inv_i  in  1  invalidate-all request; a single-cycle pulse is sufficient.
- busy_o  out  1  controller is not in IDLE.
- err_o  out  1  one-cycle pulse: bus error during a fill.
- cyc_o, stb_o  out  1  WISHBONE cycle and strobe.
- sel_o  out  4  always 4'hF while stb_o=1.
- adr_o  out  34  bus byte address; bits [1:0]=00.
- dat_i  in  32  bus read data.
- ack_i, err_i  in  1  bus acknowledge and bus error.
- cw_o  out  1  cache write strobe.
- cw_adr_o  out  34  cache write address. Bit 0 is the tag valid bit. The tag is captured when cw_adr_o[3:2]=11.
- cw_dat_o  out  32  cache write data.

## Operation

- Reset values: every output is 0. The FSM is in IDLE, the inv-pending flag is clear, and the counters are 0.
- IDLE:
  - If inv_i or inv-pending is set, go to INV. This has priority over a miss presented in the same cycle.
  - Otherwise, if chk_i=1 and hit0_i=0, go to FILL with line=pc_i[31:4]. Set need2=!hit1_i && pc_i[3].
  - Otherwise, if chk_i=1, hit1_i=0 and pc_i[3]=1, go to FILL with line=pc_i[31:4]+1 and need2=0.
  - If pc_i[3]=0, pc_i+8 lies in the same line, so a second fill is never issued.
- FILL:
  - cyc_o=stb_o=1 and adr_o={2'b00, line, word[1:0], 2'b00}. word counts 0..3.
  - On each ack_i: capture dat_i. In the next cycle drive cw_o=1, cw_adr_o=adr_o|34'd1 and cw_dat_o=the captured data. Then increment word.
  - When word 3 is acked, drop cyc_o/stb_o in the next cycle. If need2=1, go to FILL with line+1 (28-bit wrap allowed) and need2=0. Otherwise go to HOLD.
  - On err_i: drop cyc_o/stb_o in the next cycle, pulse err_o, perform no cache write for that beat, clear need2 and go to HOLD. Because the tag is written only on word 3, a line aborted before word 3 remains invalid.
  - inv_i during FILL sets inv-pending. The current fill completes before INV runs.
- INV:
  - Runs for LINES cycles. Each cycle: cw_o=1, cw_adr_o={2'b00, 18'd0, idx[9:0], 2'b11, 2'b00} with bit 0=0, cw_dat_o=0. idx counts 0..1023.
  - Clears inv-pending on entry. After idx=1023, go to HOLD.
  - inv_i during INV is ignored.
- HOLD: wait HOLD cycles with chk_i ignored, then go to IDLE.
- busy_o=1 in all states except IDLE.
- Reset mid-operation: asynchronous return to IDLE. cyc_o, stb_o and cw_o drop immediately. A partially filled line remains invalid.

## Timing

- Miss detected (chk_i) at cycle T: cyc_o=stb_o=1 at T+1 with word 0.
- Zero-wait slave: acks at T+1..T+4, cw_o at T+2..T+5, cyc_o=0 at T+5.
- stb_o stays high between beats. adr_o advances in the cycle after each ack.
- Double fill: cyc_o drops for exactly one cycle between the two lines.
- Full single-line miss with a zero-wait slave: back in IDLE at T+5+HOLD.
- Invalidate: cw_o is high for exactly LINES consecutive cycles.

## Test plan

- pc_i=0x00001238, hit0=0, hit1=1, zero-wait slave returning 0xA0..0xA3:
  - adr_o sequence 0x1230, 0x1234, 0x1238, 0x123C.
  - cw_o four times; the last has cw_adr_o=0x123D and cw_dat_o=0xA3.
  - Single fill only.
- pc_i=0x00001238, hit0=0, hit1=0: two fills, lines 0x1230 then 0x1240, with a one-cycle cyc_o gap between them.
- pc_i=0x00001230, hit0=1, hit1=0: no bus cycle, because pc_i[3]=0.
- err_i on word 2 of a fill:
  - err_o pulses once.
  - Only two cw_o writes occur, and neither has cw_adr_o[3:2]=11.
  - A second line requested by need2 is not fetched.
- inv_i pulsed during word 1 of a fill:
  - The fill completes.
  - Then 1024 cw_o writes with bit 0=0; idx 0 gives cw_adr_o=0x0000C and idx 1023 gives 0x03FFC.
  - busy_o is high throughout.
- rst_ni asserted low mid-fill with ack_i stalled: cyc_o, stb_o, cw_o and busy_o go to 0 asynchronously. After release the controller is in IDLE.

Source files
------------

// File: rtl/rtf65002_icachefill.sv
// rtf65002 I-cache line-fill and invalidate controller: fetches missing 16-byte lines over
// WISHBONE into the cache write port and runs a full invalidate sweep on request.
module rtf65002_icachefill #(
    parameter int unsigned LINES = 1024,
    parameter int unsigned HOLD  = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        chk_i,
    input  logic [31:0] pc_i,
    input  logic        hit0_i,
    input  logic        hit1_i,
    input  logic        inv_i,
    output logic        busy_o,
    output logic        err_o,
    output logic        cyc_o,
    output logic        stb_o,
    output logic [3:0]  sel_o,
    output logic [33:0] adr_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i,
    input  logic        err_i,
    output logic        cw_o,
    output logic [33:0] cw_adr_o,
    output logic [31:0] cw_dat_o
);

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StGap,
        StInv,
        StHold
    } state_t;

    localparam logic [9:0] LastIdx = 10'(LINES - 1);

    state_t      state;
    logic [27:0] line;
    logic [1:0]  word;
    logic        need2;
    logic        inv_pend;
    logic [9:0]  idx;
    logic [15:0] hold_cnt;

    // The byte offset within an 8-byte window never affects which lines are missing.
    logic unused_pc;
    assign unused_pc = ^pc_i[2:0];

    // Invalidate writes land on the tag word (bits [3:2]=11) with the valid bit clear.
    function automatic logic [33:0] inv_adr(input logic [9:0] i);
        return {2'b00, 18'd0, i, 4'b1100};
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= StIdle;
            line     <= '0;
            word     <= '0;
            need2    <= 1'b0;
            inv_pend <= 1'b0;
            idx      <= '0;
            hold_cnt <= '0;
            busy_o   <= 1'b0;
            err_o    <= 1'b0;
            cyc_o    <= 1'b0;
            stb_o    <= 1'b0;
            sel_o    <= '0;
            adr_o    <= '0;
            cw_o     <= 1'b0;
            cw_adr_o <= '0;
            cw_dat_o <= '0;
        end else begin
            err_o <= 1'b0;
            cw_o  <= 1'b0;
            if (inv_i && state != StInv) begin
                inv_pend <= 1'b1;
            end

            unique case (state)
                StIdle: begin
                    if (inv_i || inv_pend) begin
                        state    <= StInv;
                        busy_o   <= 1'b1;
                        inv_pend <= 1'b0;
                        idx      <= '0;
                        cw_o     <= 1'b1;
                        cw_adr_o <= inv_adr(10'd0);
                        cw_dat_o <= '0;
                    end else if (chk_i && !hit0_i) begin
                        state  <= StFill;
                        busy_o <= 1'b1;
                        line   <= pc_i[31:4];
                        need2  <= !hit1_i && pc_i[3];
                        word   <= '0;
                        cyc_o  <= 1'b1;
                        stb_o  <= 1'b1;
                        sel_o  <= 4'hF;
                        adr_o  <= {2'b00, pc_i[31:4], 4'b0000};
                    end else if (chk_i && !hit1_i && pc_i[3]) begin
                        state  <= StFill;
                        busy_o <= 1'b1;
                        line   <= pc_i[31:4] + 28'd1;
                        need2  <= 1'b0;
                        word   <= '0;
                        cyc_o  <= 1'b1;
                        stb_o  <= 1'b1;
                        sel_o  <= 4'hF;
                        adr_o  <= {2'b00, pc_i[31:4] + 28'd1, 4'b0000};
                    end
                end

                StFill: begin
                    if (err_i) begin
                        // Abort without writing: the tag word is never reached, line stays invalid.
                        cyc_o    <= 1'b0;
                        stb_o    <= 1'b0;
                        sel_o    <= '0;
                        err_o    <= 1'b1;
                        need2    <= 1'b0;
                        word     <= '0;
                        hold_cnt <= '0;
                        state    <= StHold;
                    end else if (ack_i) begin
                        cw_o     <= 1'b1;
                        cw_adr_o <= adr_o | 34'd1;
                        cw_dat_o <= dat_i;
                        if (word == 2'd3) begin
                            cyc_o <= 1'b0;
                            stb_o <= 1'b0;
                            sel_o <= '0;
                            word  <= '0;
                            if (need2) begin
                                line  <= line + 28'd1;
                                need2 <= 1'b0;
                                state <= StGap;
                            end else begin
                                hold_cnt <= '0;
                                state    <= StHold;
                            end
                        end else begin
                            word  <= word + 2'd1;
                            adr_o <= {2'b00, line, word + 2'd1, 2'b00};
                        end
                    end
                end

                StGap: begin
                    cyc_o <= 1'b1;
                    stb_o <= 1'b1;
                    sel_o <= 4'hF;
                    adr_o <= {2'b00, line, 4'b0000};
                    state <= StFill;
                end

                StInv: begin
                    if (idx == LastIdx) begin
                        hold_cnt <= '0;
                        state    <= StHold;
                    end else begin
                        idx      <= idx + 10'd1;
                        cw_o     <= 1'b1;
                        cw_adr_o <= inv_adr(idx + 10'd1);
                        cw_dat_o <= '0;
                    end
                end

                StHold: begin
                    if (32'(hold_cnt) + 32'd1 >= HOLD) begin
                        // A pending invalidate starts straight away so busy_o never dips.
                        if (inv_pend || inv_i) begin
                            state    <= StInv;
                            inv_pend <= 1'b0;
                            idx      <= '0;
                            cw_o     <= 1'b1;
                            cw_adr_o <= inv_adr(10'd0);
                            cw_dat_o <= '0;
                        end else begin
                            state  <= StIdle;
                            busy_o <= 1'b0;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 16'd1;
                    end
                end

                default: begin
                    state  <= StIdle;
                    busy_o <= 1'b0;
                    cyc_o  <= 1'b0;
                    stb_o  <= 1'b0;
                    sel_o  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rtf65002_icachefill.sv
// Bench for rtf65002_icachefill: vector table, corner sequences (HOLD, invalidate, reset)
// and randomized misses against a line-level reference model.
module tb_rtf65002_icachefill;
    localparam int unsigned LINES = 1024;
    localparam int unsigned HOLD  = 2;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        chk_i;
    logic [31:0] pc_i;
    logic        hit0_i, hit1_i, inv_i;
    logic        busy_o, err_o, cyc_o, stb_o;
    logic [3:0]  sel_o;
    logic [33:0] adr_o;
    logic [31:0] dat_i;
    logic        ack_i, err_i;
    logic        cw_o;
    logic [33:0] cw_adr_o;
    logic [31:0] cw_dat_o;

    rtf65002_icachefill #(.LINES(LINES), .HOLD(HOLD)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .chk_i(chk_i), .pc_i(pc_i), .hit0_i(hit0_i),
        .hit1_i(hit1_i), .inv_i(inv_i), .busy_o(busy_o), .err_o(err_o), .cyc_o(cyc_o),
        .stb_o(stb_o), .sel_o(sel_o), .adr_o(adr_o), .dat_i(dat_i), .ack_i(ack_i),
        .err_i(err_i), .cw_o(cw_o), .cw_adr_o(cw_adr_o), .cw_dat_o(cw_dat_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc_n = 0;
    int max_wait = 0;
    int err_beat = -1;
    bit stall = 1'b0;
    int beat = 0;
    int wait_left = 0;
    int err_cnt, rise_cnt, gap_len, gap_run, sel_bad, bc;
    bit cyc_prev = 1'b0;
    logic [33:0] bus_log[$];
    logic [33:0] cw_adr_log[$];
    logic [31:0] cw_dat_log[$];
    int          cw_cyc_log[$];
    logic [33:0] exp_beats[$];
    int exp_nfill, exp_nwr, exp_nerr;

    function automatic logic [31:0] data_of(input logic [33:0] a);
        return {a[27:4], 6'b101000, a[3:2]};
    endfunction

    // Slave and monitor, both working on the falling edge.
    always @(negedge clk) begin
        cyc_n++;
        if (cw_o) begin
            cw_adr_log.push_back(cw_adr_o);
            cw_dat_log.push_back(cw_dat_o);
            cw_cyc_log.push_back(cyc_n);
        end
        if (err_o) err_cnt++;
        if (stb_o && sel_o != 4'hF) sel_bad++;
        if (cyc_o && !cyc_prev) begin
            if (rise_cnt > 0) gap_len = gap_run;
            rise_cnt++;
            gap_run = 0;
        end
        if (!cyc_o) gap_run++;
        cyc_prev = cyc_o;
        ack_i = 1'b0;
        err_i = 1'b0;
        if (cyc_o && stb_o && !stall && rst_ni) begin
            if (wait_left > 0) begin
                wait_left--;
            end else begin
                if (beat == err_beat) begin
                    err_i = 1'b1;
                end else begin
                    ack_i = 1'b1;
                    dat_i = data_of(adr_o);
                end
                bus_log.push_back(adr_o);
                beat++;
                wait_left = (max_wait == 0) ? 0 : int'($urandom_range(max_wait, 0));
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        bus_log.delete();
        cw_adr_log.delete();
        cw_dat_log.delete();
        cw_cyc_log.delete();
        err_cnt  = 0;
        rise_cnt = 0;
        gap_len  = -1;
        gap_run  = 0;
        sel_bad  = 0;
        beat     = 0;
        wait_left = (max_wait == 0) ? 0 : int'($urandom_range(max_wait, 0));
    endtask

    task automatic present(input logic [31:0] pc, input bit h0, input bit h1,
                           input int mw, input int eb);
        @(negedge clk); #1;
        max_wait = mw;
        err_beat = eb;
        clear_logs();
        chk_i  = 1'b1;
        pc_i   = pc;
        hit0_i = h0;
        hit1_i = h1;
        @(negedge clk); #1;
        chk_i  = 1'b0;
        hit0_i = 1'b1;
        hit1_i = 1'b1;
    endtask

    // Counts busy cycles; returns once the controller has been idle for a while.
    task automatic wait_idle(output int busy_cyc);
        busy_cyc = 0;
        for (int i = 0; i < 5000; i++) begin
            if (busy_o) busy_cyc++;
            else if (i >= 8) return;
            @(negedge clk); #1;
        end
        check("idle timeout", 64'(busy_o), 64'd0);
    endtask

    // Missing lines first, then the beats they expand to, truncated at the erroring beat.
    task automatic model(input logic [31:0] pc, input bit h0, input bit h1, input int eb);
        logic [27:0] lines[$];
        exp_beats.delete();
        exp_nfill = 0;
        exp_nwr   = 0;
        exp_nerr  = 0;
        if (!h0) lines.push_back(pc[31:4]);
        if (pc[3] && !h1) lines.push_back(pc[31:4] + 28'd1);
        foreach (lines[l]) begin
            exp_nfill++;
            for (int w = 0; w < 4; w++) begin
                exp_beats.push_back({2'b00, lines[l], 2'(w), 2'b00});
                if (exp_beats.size() - 1 == eb) begin
                    exp_nerr = 1;
                    return;
                end
                exp_nwr++;
            end
        end
    endtask

    task automatic compare_logs(input string tag);
        check({tag, " fills"}, 64'(rise_cnt), 64'(exp_nfill));
        check({tag, " errs"}, 64'(err_cnt), 64'(exp_nerr));
        check({tag, " beats"}, 64'(bus_log.size()), 64'(exp_beats.size()));
        check({tag, " writes"}, 64'(cw_adr_log.size()), 64'(exp_nwr));
        check({tag, " sel"}, 64'(sel_bad), 64'd0);
        for (int i = 0; i < exp_beats.size() && i < bus_log.size(); i++)
            check({tag, " adr"}, 64'(bus_log[i]), 64'(exp_beats[i]));
        for (int i = 0; i < exp_nwr && i < cw_adr_log.size(); i++) begin
            check({tag, " cw_adr"}, 64'(cw_adr_log[i]), 64'(exp_beats[i] | 34'd1));
            check({tag, " cw_dat"}, 64'(cw_dat_log[i]), 64'(data_of(exp_beats[i])));
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        bit          h0;
        bit          h1;
        int          eb;
        int          nfill;
        int          nwr;
        logic [33:0] last_cw;
        int          nerr;
        int          busy;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h0000_1238, 1'b0, 1'b1, -1, 1, 4, 34'h123D, 0, 6};
        vecs[1] = '{32'h0000_1238, 1'b0, 1'b0, -1, 2, 8, 34'h124D, 0, 11};
        vecs[2] = '{32'h0000_1230, 1'b1, 1'b0, -1, 0, 0, 34'h0, 0, 0};
        vecs[3] = '{32'h0000_1238, 1'b1, 1'b0, -1, 1, 4, 34'h124D, 0, 6};
        vecs[4] = '{32'h0000_1238, 1'b0, 1'b0, 2, 1, 2, 34'h1235, 1, 5};
        vecs[5] = '{32'h0000_1238, 1'b1, 1'b1, -1, 0, 0, 34'h0, 0, 0};
        vecs[6] = '{32'hFFFF_FFF8, 1'b0, 1'b0, -1, 2, 8, 34'h000D, 0, 11};
        vecs[7] = '{32'h0000_1230, 1'b0, 1'b0, -1, 1, 4, 34'h123D, 0, 6};
        vecs[8] = '{32'h0000_5678, 1'b0, 1'b0, 5, 2, 5, 34'h5681, 1, 9};

        rst_ni = 1'b0;
        chk_i  = 1'b0;
        pc_i   = '0;
        hit0_i = 1'b1;
        hit1_i = 1'b1;
        inv_i  = 1'b0;
        dat_i  = '0;
        ack_i  = 1'b0;
        err_i  = 1'b0;
        #1;
        check("reset ctl", 64'({busy_o, err_o, cyc_o, stb_o, cw_o, sel_o}), 64'd0);
        check("reset adr", 64'(adr_o), 64'd0);
        check("reset cw_adr", 64'(cw_adr_o), 64'd0);
        check("reset cw_dat", 64'(cw_dat_o), 64'd0);
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;

        // Table vectors with a zero-wait slave.
        foreach (vecs[k]) begin
            present(vecs[k].pc, vecs[k].h0, vecs[k].h1, 0, vecs[k].eb);
            wait_idle(bc);
            check($sformatf("vec%0d fills", k), 64'(rise_cnt), 64'(vecs[k].nfill));
            check($sformatf("vec%0d writes", k), 64'(cw_adr_log.size()), 64'(vecs[k].nwr));
            check($sformatf("vec%0d errs", k), 64'(err_cnt), 64'(vecs[k].nerr));
            check($sformatf("vec%0d busy", k), 64'(bc), 64'(vecs[k].busy));
            if (vecs[k].nwr > 0 && cw_adr_log.size() > 0)
                check($sformatf("vec%0d last cw", k), 64'(cw_adr_log[$]), 64'(vecs[k].last_cw));
            if (vecs[k].nfill == 2 && vecs[k].eb < 0)
                check($sformatf("vec%0d gap", k), 64'(gap_len), 64'd1);
            model(vecs[k].pc, vecs[k].h0, vecs[k].h1, vecs[k].eb);
            compare_logs($sformatf("vec%0d", k));
        end

        // A miss presented during HOLD is ignored.
        present(32'h0000_1238, 1'b0, 1'b1, 0, -1);
        fork
            begin
                repeat (4) @(negedge clk);
                #1 chk_i = 1'b1; pc_i = 32'h0000_2000; hit0_i = 1'b0;
                repeat (2) @(negedge clk);
                #1 chk_i = 1'b0; hit0_i = 1'b1;
            end
            wait_idle(bc);
        join
        check("hold fills", 64'(rise_cnt), 64'd1);
        check("hold busy", 64'(bc), 64'd6);

        // Invalidate requested during word 1 of a fill.
        present(32'h0000_1238, 1'b0, 1'b1, 0, -1);
        fork
            begin
                @(negedge clk); #1 inv_i = 1'b1;
                @(negedge clk); #1 inv_i = 1'b0;
            end
            wait_idle(bc);
        join
        check("inv busy", 64'(bc), 64'(4 + 2 * HOLD + LINES));
        check("inv fills", 64'(rise_cnt), 64'd1);
        check("inv writes", 64'(cw_adr_log.size()), 64'(4 + LINES));
        if (cw_adr_log.size() == 4 + LINES) begin
            int bad = 0;
            check("inv fill tag", 64'(cw_adr_log[3]), 64'h123D);
            check("inv idx0", 64'(cw_adr_log[4]), 64'h0000C);
            check("inv idx1023", 64'(cw_adr_log[4 + LINES - 1]), 64'h03FFC);
            for (int i = 0; i < LINES; i++) begin
                logic [33:0] ea;
                ea = {2'b00, 18'd0, 10'(i), 4'b1100};
                if (cw_adr_log[4 + i] !== ea || cw_dat_log[4 + i] !== 32'd0 ||
                    cw_cyc_log[4 + i] != cw_cyc_log[4] + i) bad++;
            end
            check("inv sweep bad entries", 64'(bad), 64'd0);
        end

        // Reset asserted mid-fill with a stalled slave.
        stall = 1'b1;
        present(32'h0000_1238, 1'b0, 1'b1, 0, -1);
        repeat (2) @(negedge clk);
        check("stall busy", 64'({busy_o, cyc_o, stb_o}), 64'h7);
        #2 rst_ni = 1'b0;
        #1 check("async rst fill", 64'({cyc_o, stb_o, cw_o, busy_o}), 64'd0);
        stall = 1'b0;
        @(negedge clk); #1 rst_ni = 1'b1;
        repeat (3) @(negedge clk);
        check("post rst idle", 64'({busy_o, cyc_o}), 64'd0);

        // Reset during the invalidate sweep drops the cache write at once.
        @(negedge clk); #1 inv_i = 1'b1;
        @(negedge clk); #1 inv_i = 1'b0;
        repeat (10) @(negedge clk);
        check("inv running", 64'({cw_o, busy_o}), 64'h3);
        #2 rst_ni = 1'b0;
        #1 check("async rst inv", 64'({cw_o, busy_o}), 64'd0);
        @(negedge clk); #1 rst_ni = 1'b1;
        present(32'h0000_1238, 1'b0, 1'b1, 0, -1);
        wait_idle(bc);
        model(32'h0000_1238, 1'b0, 1'b1, -1);
        compare_logs("after rst");

        // Randomized misses, wait states and bus errors.
        for (int n = 0; n < 40; n++) begin
            logic [31:0] pc;
            bit h0, h1;
            int mw, eb;
            pc = $urandom;
            h0 = 1'($urandom_range(1, 0));
            h1 = 1'($urandom_range(1, 0));
            mw = int'($urandom_range(3, 0));
            eb = ($urandom_range(4, 0) == 0) ? int'($urandom_range(7, 0)) : -1;
            present(pc, h0, h1, mw, eb);
            wait_idle(bc);
            model(pc, h0, h1, eb);
            compare_logs($sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
